mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multiply/divide unit in the execute stage, beside the ALU. It takes the same rs/rt operand
//  pair and owns the HI/LO registers used by MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  A multiply or divide occupies the unit for a fixed number of cycles.
//  `busy` tells the hazard unit when to stall MFHI/MFLO and any following mul/div instruction.
// PARAMETERS
//  MUL_CYCLES  5   cycles from accepted MULT/MULTU to HI/LO update (>=1)
//  DIV_CYCLES  10  cycles from accepted DIV/DIVU to HI/LO update (>=1)
// PORTS
//  clk       in   1   clock, all state on rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  start     in   1   op valid this cycle (EX stage holds an MD instruction, not stalled/flushed)
//  md_op     in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (=NONE)
//  rs_val    in   32  operand A / MTHI-MTLO source (forwarded value)
//  rt_val    in   32  operand B
//  busy      out  1   registered; high while a mul/div is in flight
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (reset_n=0, async): busy=0, hi=0, lo=0, counter=0, pending results=0, state IDLE.
//  - States: IDLE, RUN. Counter width ceil(log2(max(MUL_CYCLES,DIV_CYCLES)+1)).
//  - IDLE, start=1, md_op in {1..4} at edge T:
//    - Latch operands and compute pending {hi,lo}.
//    - Counter <= MUL_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); go to RUN; busy=1 after T.
//  - RUN: counter decrements each edge. On the edge where it reaches 0:
//    - hi/lo <= pending, busy <= 0, state IDLE. Results visible from edge T+N, N=op latency.
//  - busy is high for exactly N cycles; hi/lo hold old values throughout.
//  - MTHI/MTLO (start=1, IDLE): hi (or lo) <= rs_val at that edge; busy stays 0; 1-cycle effect.
//  - start while RUN (any op): ignored; no state change. The hazard unit must prevent this.
//    The bench checks that it is ignored.
//  - md_op NONE/reserved with start=1: no effect.
//  - MULT: signed 32x32 -> 64; hi=prod[63:32], lo=prod[31:0]. MULTU: unsigned.
//  - DIV: signed, quotient truncates toward zero; lo=quotient, hi=remainder (sign of dividend).
//    - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (no trap).
//  - DIVU: unsigned; lo=quotient, hi=remainder.
//  - Divisor 0 (DIV or DIVU): full latency, busy behaves normally, hi/lo left unchanged at
//    completion.
//  - Operands are sampled only at the accept edge. Later changes on rs_val/rt_val are ignored.
//  - Reset asserted mid-RUN: immediate abort, all outputs to reset values; pending results lost.
//  - No exceptions or overflow are reported; the ALU overflow path is separate.
// TESTING
//  1. MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
//  3. DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIVU 7/2 -> lo=3, hi=1.
//  4. DIV x/0 after MTHI 0x1234, MTLO 0x5678 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged.
//     Separately 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5. MULT accepted, then MTHI 0xAAAA with start=1 on cycle 2 of RUN -> ignored.
//     Final hi/lo = product; the MTHI at IDLE after completion writes hi=0xAAAA next edge.
//  6. Drop reset_n at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately.
//     After release, a new MULT 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multiply/divide unit beside the ALU. Owns HI/LO and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// A mul/div result is computed when the op is accepted and held as a pending value.
// The unit then counts down the op latency and commits the pending value to HI/LO at the end.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | free: accepts mul/div, MTHI/MTLO write HI/LO directly
// S_RUN  | mul/div in flight: counter running, busy high, every start ignored
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [31:0]     r_pend_hi;
  logic [31:0]     r_pend_lo;
  logic            r_pend_wr;

  logic            w_is_mul;
  logic            w_is_div;
  logic            w_accept;
  logic            w_done;
  logic            w_wr_hi;
  logic            w_wr_lo;

  logic [63:0]     w_a_ext;
  logic [63:0]     w_b_ext;
  logic [63:0]     w_prod;

  logic            w_div_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [31:0]     w_a_mag;
  logic [31:0]     w_b_mag;
  logic [31:0]     w_b_safe;
  logic [31:0]     w_q_mag;
  logic [31:0]     w_r_mag;
  logic [31:0]     w_quot;
  logic [31:0]     w_rem;

  logic [31:0]     w_pend_hi;
  logic [31:0]     w_pend_lo;
  logic            w_pend_wr;

  assign w_is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign w_is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign w_accept = start && (r_state == S_IDLE) && (w_is_mul || w_is_div);
  assign w_done   = (r_state == S_RUN) && (r_cnt == CW'(1));
  assign w_wr_hi  = start && (r_state == S_IDLE) && (md_op == OP_MTHI);
  assign w_wr_lo  = start && (r_state == S_IDLE) && (md_op == OP_MTLO);

  // One 64-bit multiplier serves both flavours; signed operands are sign-extended so the
  // low 64 bits of the unsigned product equal the signed product.
  assign w_a_ext = {{32{(md_op == OP_MULT) & rs_val[31]}}, rs_val};
  assign w_b_ext = {{32{(md_op == OP_MULT) & rt_val[31]}}, rt_val};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide is done on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with no
  // special case. A zero divisor is swapped for 1 only to keep the divider well defined;
  // its result is never committed.
  assign w_div_signed = (md_op == OP_DIV);
  assign w_a_neg      = w_div_signed & rs_val[31];
  assign w_b_neg      = w_div_signed & rt_val[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - rs_val) : rs_val;
  assign w_b_mag      = w_b_neg ? (32'd0 - rt_val) : rt_val;
  assign w_b_safe     = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Select the result that will be committed when the op completes.
  always_comb begin
    w_pend_hi = w_prod[63:32];
    w_pend_lo = w_prod[31:0];
    w_pend_wr = 1'b1;
    if (w_is_div) begin
      w_pend_hi = w_rem;
      w_pend_lo = w_quot;
      w_pend_wr = (rt_val != 32'd0);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_done)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Latency counter, busy flag and pending result captured at accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= w_is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
      r_busy    <= 1'b1;
      r_pend_hi <= w_pend_hi;
      r_pend_lo <= w_pend_lo;
      r_pend_wr <= w_pend_wr;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_done) r_busy <= 1'b0;
    end
  end

  // HI/LO: commit at mul/div completion, or direct MTHI/MTLO write while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_done) begin
      if (r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else begin
      if (w_wr_hi) r_hi <= rs_val;
      if (w_wr_lo) r_lo <= rs_val;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a timeline model (accept edge + latency, plain arithmetic results)
// compared against the DUT on every falling edge, plus literal expectations for known cases.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference results from plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output bit wr, output logic [31:0] rhi, output logic [31:0] rlo);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    wr = 1'b1; rhi = 32'd0; rlo = 32'd0;
    sa = a; sb = b;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); rhi = sp[63:32]; rlo = sp[31:0]; end
      3'd2: begin up = 64'(a) * 64'(b); rhi = up[63:32]; rlo = up[31:0]; end
      3'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin rlo = 32'h80000000; rhi = 32'd0; end
        else begin rlo = sa / sb; rhi = sa % sb; end
      end
      3'd4: begin
        if (b == 32'd0) wr = 1'b0;
        else begin rlo = a / b; rhi = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // Model: a mul/div accepted at edge c finishes at edge c+N; busy is high in between.
  int          m_cyc = 0;
  int          m_done = 0;
  bit          m_busy = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_wr = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_hi = 32'd0; m_lo = 32'd0; p_wr = 1'b0;
    end else begin
      m_cyc++;
      if (m_busy) begin
        if (m_cyc == m_done) begin
          if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
          m_busy = 1'b0;
        end
      end else if (start) begin
        case (md_op)
          3'd1, 3'd2: begin ref_op(md_op, rs_val, rt_val, p_wr, p_hi, p_lo); m_busy = 1'b1; m_done = m_cyc + 5; end
          3'd3, 3'd4: begin ref_op(md_op, rs_val, rt_val, p_wr, p_hi, p_lo); m_busy = 1'b1; m_done = m_cyc + 10; end
          3'd5: m_hi = rs_val;
          3'd6: m_lo = rs_val;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    checks += 3;
    if (busy !== m_busy) begin errors++; $display("FAIL cyc_busy t=%0t got %b want %b", $time, busy, m_busy); end
    if (hi !== m_hi)     begin errors++; $display("FAIL cyc_hi t=%0t got %h want %h", $time, hi, m_hi); end
    if (lo !== m_lo)     begin errors++; $display("FAIL cyc_lo t=%0t got %h want %h", $time, lo, m_lo); end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %h want %h", name, act, exp); end
  endtask

  // Called at a falling edge; the op is presented for exactly one rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    checks++;
    if (busy) begin errors++; $display("FAIL wait_idle got busy=1 want busy=0 after %0d cycles", n); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    measure_busy(n);
    check("mult_busy_len", 32'(n), 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    measure_busy(n);
    check("multu_busy_len", 32'(n), 32'd5);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    measure_busy(n);
    check("div_busy_len", 32'(n), 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd4, 32'd7, 32'd2);
    wait_idle();
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(3'd5, 32'h1234, 32'd0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", 32'(busy), 32'd0);
    issue(3'd6, 32'h5678, 32'd0);
    check("mtlo_lo", lo, 32'h5678);
    issue(3'd3, 32'd5, 32'd0);
    measure_busy(n);
    check("div0_busy_len", 32'(n), 32'd10);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'd0);

    issue(3'd1, 32'h1000, 32'd3);
    @(negedge clk);
    issue(3'd5, 32'hAAAA, 32'd0);
    wait_idle();
    check("ignored_hi", hi, 32'd0);
    check("ignored_lo", lo, 32'h3000);
    issue(3'd5, 32'hAAAA, 32'd0);
    check("mthi_after_hi", hi, 32'hAAAA);
    check("mthi_after_lo", lo, 32'h3000);

    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    issue(3'd1, 32'd6, 32'd7);
    wait_idle();
    check("post_reset_lo", lo, 32'd42);
    check("post_reset_hi", hi, 32'd0);

    repeat (1500) begin
      start  = ($urandom_range(0, 2) != 0);
      md_op  = 3'($urandom_range(0, 7));
      rs_val = pick_operand();
      rt_val = pick_operand();
      @(negedge clk);
    end
    start = 1'b0;
    md_op = 3'd0;
    wait_idle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
